// File: rtl/coin_front_end.sv
// Coin-sensor front end: synchronizes, debounces and arms three raw coin lines,
// queues accepted coins and replays them to the controller as spaced single-cycle pulses.
module coin_front_end #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned GAP      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Raw100,
    input  logic       Raw200,
    input  logic       Raw500,
    output logic       Coin100,
    output logic       Coin200,
    output logic       Coin500,
    output logic       Reject,
    output logic       Overflow,
    output logic [2:0] Pending
);
    localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE);
    localparam logic [3:0] DEB_ARM = 4'(DEBOUNCE - 1);
    localparam logic [3:0] GAP_LEN = 4'(GAP);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

    logic [2:0] raw;
    logic [2:0] sync_a;
    logic [2:0] sync_b;
    logic [2:0] armed;
    logic [2:0] qualify;
    logic [1:0] fill;
    logic [3:0] cnt [3];

    logic       collision;
    logic       wr_req;
    logic       wr_ok;
    logic       pop;
    logic [1:0] wr_code;
    logic [1:0] mem [4];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;
    logic [2:0] count;

    state_t     state;
    state_t     state_next;
    logic [3:0] gap_cnt;
    logic [1:0] cur_code;

    assign raw = {Raw500, Raw200, Raw100};

    // A low level arms a channel only once the synchronizer holds a real sample of
    // the line, so a sensor held high across reset release never arms.
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= '0;
            sync_b <= '0;
            fill   <= '0;
            armed  <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (fill != 2'd2) fill <= fill + 2'd1;
            for (int i = 0; i < 3; i++) begin
                if (fill == 2'd2 && !sync_b[i]) armed[i] <= 1'b1;
                if (!sync_b[i])             cnt[i] <= '0;
                else if (cnt[i] < DEB_MAX)  cnt[i] <= cnt[i] + 4'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) qualify[i] = armed[i] & sync_b[i] & (cnt[i] == DEB_ARM);
    end

    assign collision = (qualify[0] & qualify[1]) | (qualify[0] & qualify[2]) | (qualify[1] & qualify[2]);
    assign wr_req    = (|qualify) & ~collision;
    assign wr_code   = qualify[2] ? 2'd3 : (qualify[1] ? 2'd2 : 2'd1);
    assign pop       = (state == S_IDLE) && (count != 3'd0);
    // A full FIFO still takes the write when the same edge frees a slot.
    assign wr_ok     = wr_req && ((count != 3'd4) || pop);

    // NOTE: the storage array needs no reset; pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_code;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            Reject   <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            if (pop)   rd_ptr <= rd_ptr + 2'd1;
            if (wr_ok) wr_ptr <= wr_ptr + 2'd1;
            case ({wr_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: ;
            endcase
            Reject <= collision;
            if (wr_req && !wr_ok) Overflow <= 1'b1;
        end
    end

    assign Pending = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (count != 3'd0) state_next = S_PULSE;
            S_PULSE: state_next = (GAP_LEN != 4'd0) ? S_GAP : S_IDLE;
            S_GAP:   if (gap_cnt <= 4'd1) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_cnt  <= '0;
            cur_code <= '0;
        end else begin
            if (pop) cur_code <= mem[rd_ptr];
            if (state == S_PULSE)    gap_cnt <= GAP_LEN;
            else if (state == S_GAP) gap_cnt <= gap_cnt - 4'd1;
        end
    end

    // NOTE: outputs get defaults first so no path through the block infers a latch.
    always_comb begin
        Coin100 = 1'b0;
        Coin200 = 1'b0;
        Coin500 = 1'b0;
        if (state == S_PULSE) begin
            case (cur_code)
                2'd1:    Coin100 = 1'b1;
                2'd2:    Coin200 = 1'b1;
                2'd3:    Coin500 = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_coin_front_end.sv
// Bench for coin_front_end: two instances (GAP=2 and GAP=15) against a history-based
// model that derives qualify edges from the sampled raw lines and replays a coin queue.
module tb_coin_front_end;
    localparam int D     = 4;
    localparam int GAP_A = 2;
    localparam int GAP_B = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] raw = 3'b000;

    logic       c100_a, c200_a, c500_a, rej_a, ovf_a;
    logic [2:0] pend_a;
    logic       c100_b, c200_b, c500_b, rej_b, ovf_b;
    logic [2:0] pend_b;

    int checks = 0;
    int failures = 0;

    logic [2:0] hist[$];
    int         n;
    int         mq[2][$];
    int         next_pop[2];
    logic [7:0] exp_u[2];
    logic       exp_ovf[2];
    logic       prev_ovf[2];

    coin_front_end #(.DEBOUNCE(D), .GAP(GAP_A)) dut_a (
        .clk(clk), .reset(reset), .Raw100(raw[0]), .Raw200(raw[1]), .Raw500(raw[2]),
        .Coin100(c100_a), .Coin200(c200_a), .Coin500(c500_a),
        .Reject(rej_a), .Overflow(ovf_a), .Pending(pend_a)
    );

    coin_front_end #(.DEBOUNCE(D), .GAP(GAP_B)) dut_b (
        .clk(clk), .reset(reset), .Raw100(raw[0]), .Raw200(raw[1]), .Raw500(raw[2]),
        .Coin100(c100_b), .Coin200(c200_b), .Coin500(c500_b),
        .Reject(rej_b), .Overflow(ovf_b), .Pending(pend_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached at edge %0d", n);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] obs_vec();
        return {c500_a, c200_a, c100_a, rej_a, ovf_a, pend_a,
                c500_b, c200_b, c100_b, rej_b, ovf_b, pend_b};
    endfunction

    function automatic logic [15:0] exp_vec();
        return {exp_u[0], exp_u[1]};
    endfunction

    // Overflow is compared only once its expected value has been stable for an edge.
    function automatic logic [15:0] cmp_mask();
        return {4'hF, prev_ovf[0] == exp_ovf[0], 3'b111, 4'hF, prev_ovf[1] == exp_ovf[1], 3'b111};
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(3'b000);
        n = 0;
        for (int u = 0; u < 2; u++) begin
            mq[u].delete();
            next_pop[u] = 0;
            exp_u[u]    = '0;
            exp_ovf[u]  = 1'b0;
            prev_ovf[u] = 1'b0;
        end
    endtask

    // Drive one raw vector for one cycle and advance the model by one rising edge.
    task automatic step(input logic [2:0] r);
        logic [2:0] qual;
        logic [2:0] coin;
        logic       ok;
        int         nq;
        int         code;
        int         gap;
        @(negedge clk);
        raw = r;
        @(posedge clk);
        n++;
        hist.push_back(r);
        qual = '0;
        for (int ch = 0; ch < 3; ch++) begin
            if (n - D - 2 >= 1) begin
                ok = !hist[n - D - 2][ch];
                for (int k = n - D - 1; k <= n - 2; k++) if (!hist[k][ch]) ok = 1'b0;
                qual[ch] = ok;
            end
        end
        nq = $countones(qual);
        code = qual[2] ? 3 : (qual[1] ? 2 : 1);
        for (int u = 0; u < 2; u++) begin
            gap = (u == 0) ? GAP_A : GAP_B;
            prev_ovf[u] = exp_ovf[u];
            coin = '0;
            if (n >= next_pop[u] && mq[u].size() > 0) begin
                coin[mq[u].pop_front() - 1] = 1'b1;
                next_pop[u] = n + gap + 2;
            end
            if (nq == 1) begin
                if (mq[u].size() < 4) mq[u].push_back(code);
                else                  exp_ovf[u] = 1'b1;
            end
            exp_u[u] = {coin[2], coin[1], coin[0], nq > 1, exp_ovf[u], 3'(mq[u].size())};
        end
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] got, want, msk;
        model_reset();
        #2 reset = 1'b0;
        #1;
        got = obs_vec(); want = exp_vec(); msk = cmp_mask();
        checks++;
        if ((got & msk) !== (want & msk)) begin
            failures++;
            $display("FAIL reset_hold got=%h want=%h", got & msk, want & msk);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(3'b000);
            got = obs_vec(); want = exp_vec(); msk = cmp_mask();
            checks++;
            if ((got & msk) !== (want & msk)) begin
                failures++;
                $display("FAIL reset_idle edge=%0d got=%h want=%h", n, got & msk, want & msk);
            end
        end
    endtask

    task automatic test_basic();
        logic [15:0] got, want, msk;
        int first_edge, pulses, pulse_edge;
        pulses = 0; pulse_edge = -1; first_edge = 0;
        for (int i = 0; i < 30; i++) begin
            step((i < 10) ? 3'b010 : 3'b000);
            if (i == 0) first_edge = n;
            if (c200_a) begin pulses++; pulse_edge = n; end
            got = obs_vec(); want = exp_vec(); msk = cmp_mask();
            checks++;
            if ((got & msk) !== (want & msk)) begin
                failures++;
                $display("FAIL basic edge=%0d got=%h want=%h", n, got & msk, want & msk);
            end
        end
        checks++;
        if (pulses !== 1 || pulse_edge !== first_edge + D + 2) begin
            failures++;
            $display("FAIL basic_timing pulses=%0d at_edge=%0d want 1 at %0d", pulses, pulse_edge, first_edge + D + 2);
        end
    endtask

    task automatic test_bounce();
        logic [15:0] got, want, msk;
        logic        hi;
        int first_edge, pulses, pulse_edge;
        pulses = 0; pulse_edge = -1; first_edge = 0;
        for (int i = 0; i < 35; i++) begin
            hi = (i < 3) || (i >= 4 && i < 7) || (i >= 8 && i < 16);
            step({2'b00, hi});
            if (i == 8) first_edge = n;
            if (c100_a) begin pulses++; pulse_edge = n; end
            got = obs_vec(); want = exp_vec(); msk = cmp_mask();
            checks++;
            if ((got & msk) !== (want & msk)) begin
                failures++;
                $display("FAIL bounce edge=%0d got=%h want=%h", n, got & msk, want & msk);
            end
        end
        checks++;
        if (pulses !== 1 || pulse_edge !== first_edge + D + 2) begin
            failures++;
            $display("FAIL bounce_timing pulses=%0d at_edge=%0d want 1 at %0d", pulses, pulse_edge, first_edge + D + 2);
        end
    endtask

    task automatic test_serial();
        logic [15:0] got, want, msk;
        logic [2:0]  r;
        int seen[$];
        int low_run;
        low_run = 0;
        for (int i = 0; i < 60; i++) begin
            r = {i >= 2 && i < 10, i >= 1 && i < 9, i < 8};
            step(r);
            if ({c500_a, c200_a, c100_a} != 3'b000) begin
                if (seen.size() > 0) begin
                    checks++;
                    if (low_run !== GAP_A + 1) begin
                        failures++;
                        $display("FAIL serial_gap low_cycles=%0d want=%0d", low_run, GAP_A + 1);
                    end
                end
                seen.push_back(c500_a ? 3 : (c200_a ? 2 : 1));
                low_run = 0;
            end else begin
                low_run++;
            end
            got = obs_vec(); want = exp_vec(); msk = cmp_mask();
            checks++;
            if ((got & msk) !== (want & msk)) begin
                failures++;
                $display("FAIL serial edge=%0d got=%h want=%h", n, got & msk, want & msk);
            end
        end
        checks++;
        if (seen.size() !== 3) begin
            failures++;
            $display("FAIL serial_count pulses=%0d want=3", seen.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (seen[k] !== k + 1) begin
                    failures++;
                    $display("FAIL serial_order slot=%0d code=%0d want=%0d", k, seen[k], k + 1);
                end
            end
        end
    endtask

    task automatic test_collision();
        logic [15:0] got, want, msk;
        int rejects, coins;
        rejects = 0; coins = 0;
        for (int i = 0; i < 25; i++) begin
            step((i < 10) ? 3'b101 : 3'b000);
            if (rej_a) rejects++;
            if (c100_a || c200_a || c500_a) coins++;
            got = obs_vec(); want = exp_vec(); msk = cmp_mask();
            checks++;
            if ((got & msk) !== (want & msk)) begin
                failures++;
                $display("FAIL collision edge=%0d got=%h want=%h", n, got & msk, want & msk);
            end
        end
        checks++;
        if (rejects !== 1 || coins !== 0) begin
            failures++;
            $display("FAIL collision_count rejects=%0d coins=%0d want 1 and 0", rejects, coins);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] got, want, msk;
        logic [2:0]  r;
        int max_pend, coins_b;
        max_pend = 0; coins_b = 0;
        for (int i = 0; i < 95; i++) begin
            r[0] = (i < 5) || (i >= 6 && i < 11);
            r[1] = (i >= 1 && i < 6) || (i >= 7 && i < 12);
            r[2] = (i >= 2 && i < 7) || (i >= 8 && i < 13);
            step(r);
            if (int'(pend_b) > max_pend) max_pend = int'(pend_b);
            if (c100_b || c200_b || c500_b) coins_b++;
            got = obs_vec(); want = exp_vec(); msk = cmp_mask();
            checks++;
            if ((got & msk) !== (want & msk)) begin
                failures++;
                $display("FAIL overflow edge=%0d got=%h want=%h", n, got & msk, want & msk);
            end
        end
        checks++;
        if (max_pend !== 4 || ovf_b !== 1'b1 || coins_b !== 5) begin
            failures++;
            $display("FAIL overflow_summary max_pending=%0d overflow=%b coins=%0d want 4 1 5", max_pend, ovf_b, coins_b);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got, want, msk;
        logic [2:0]  r;
        int early, late;
        early = 0; late = 0;
        for (int i = 0; i < 12; i++) begin
            r = {i >= 2, (i >= 1 && i < 5) || i >= 6, i >= 3};
            step(r);
            got = obs_vec(); want = exp_vec(); msk = cmp_mask();
            checks++;
            if ((got & msk) !== (want & msk)) begin
                failures++;
                $display("FAIL reset_mid_setup edge=%0d got=%h want=%h", n, got & msk, want & msk);
            end
        end
        checks++;
        if (c500_a !== 1'b1 || pend_a !== 3'd2) begin
            failures++;
            $display("FAIL reset_mid_precondition coin500=%b pending=%0d want 1 2", c500_a, pend_a);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        got = obs_vec(); want = exp_vec(); msk = cmp_mask();
        checks++;
        if ((got & msk) !== (want & msk)) begin
            failures++;
            $display("FAIL reset_mid_clear got=%h want=%h", got & msk, want & msk);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            r = (i < 20 || (i >= 23 && i < 33)) ? 3'b001 : 3'b000;
            step(r);
            if (c100_a) begin
                if (i < 20) early++;
                else        late++;
            end
            got = obs_vec(); want = exp_vec(); msk = cmp_mask();
            checks++;
            if ((got & msk) !== (want & msk)) begin
                failures++;
                $display("FAIL reset_mid_after edge=%0d got=%h want=%h", n, got & msk, want & msk);
            end
        end
        checks++;
        if (early !== 0 || late !== 1) begin
            failures++;
            $display("FAIL reset_mid_rearm held_high_pulses=%0d rearmed_pulses=%0d want 0 1", early, late);
        end
    endtask

    task automatic test_random();
        logic [15:0] got, want, msk;
        logic [2:0]  r;
        int hold[3];
        r = 3'b000;
        for (int ch = 0; ch < 3; ch++) hold[ch] = $urandom_range(1, 7);
        for (int i = 0; i < 680; i++) begin
            for (int ch = 0; ch < 3; ch++) begin
                if (hold[ch] == 0) begin
                    r[ch]    = ~r[ch];
                    hold[ch] = $urandom_range(1, 7);
                end
                hold[ch]--;
            end
            step((i < 600) ? r : 3'b000);
            got = obs_vec(); want = exp_vec(); msk = cmp_mask();
            checks++;
            if ((got & msk) !== (want & msk)) begin
                failures++;
                $display("FAIL random edge=%0d got=%h want=%h", n, got & msk, want & msk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bounce();
        test_serial();
        test_collision();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
